// File: rtl/gcn_mem_pkg.sv
// gcn_mem_pkg: shared sizes, types and address decode for gcn_fm_wm_memory
package gcn_mem_pkg;
  localparam int FEATURE_COLS = 96;
  localparam int WEIGHT_ROWS = 96;
  localparam int FEATURE_ROWS = 6;
  localparam int WEIGHT_COLS = 3;
  localparam int WEIGHT_WIDTH = 5;
  localparam int FEATURE_WIDTH = WEIGHT_WIDTH;
  localparam int ADDRESS_WIDTH = 13;
  localparam int ROW_LEN = WEIGHT_ROWS;
  localparam int COL_W = $clog2(ROW_LEN);
  localparam int ROW_IDX_W = $clog2(FEATURE_ROWS > WEIGHT_COLS ? FEATURE_ROWS : WEIGHT_COLS);
  localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 13'd512;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);
  typedef enum logic {IDLE, LOAD} load_state_t;
  typedef enum logic [1:0] {BANK_WEIGHT, BANK_FEATURE, BANK_NONE} bank_sel_t;
  typedef struct packed {
    bank_sel_t bank;
    logic [ROW_IDX_W-1:0] row;
  } decode_t;
  function automatic decode_t decode_addr(input logic [ADDRESS_WIDTH-1:0] a);
    logic feat = a >= FEATURE_BASE;
    logic [ADDRESS_WIDTH-1:0] row = feat ? a - FEATURE_BASE : a;
    logic ok = feat ? row < ADDRESS_WIDTH'(FEATURE_ROWS) : row < ADDRESS_WIDTH'(WEIGHT_COLS);
    return '{bank: ok ? (feat ? BANK_FEATURE : BANK_WEIGHT) : BANK_NONE, row: ROW_IDX_W'(row)};
  endfunction
endpackage

// File: rtl/gcn_fm_wm_memory_if.sv
// gcn_fm_wm_memory_if: row-read and element-load bus between the row memory and its host/consumer
interface gcn_fm_wm_memory_if;
  import gcn_mem_pkg::*;
  logic enable_read;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic [WEIGHT_WIDTH-1:0] data_in [0:WEIGHT_ROWS-1];
  logic data_valid;
  logic load_start;
  logic [ADDRESS_WIDTH-1:0] load_address;
  logic load_valid;
  logic [WEIGHT_WIDTH-1:0] load_data;
  logic load_ready;
  logic load_done;
  logic addr_error;
  modport master(
    output enable_read, read_address, load_start, load_address, load_valid, load_data,
    input data_in, data_valid, load_ready, load_done, addr_error
  );
  modport slave(
    input enable_read, read_address, load_start, load_address, load_valid, load_data,
    output data_in, data_valid, load_ready, load_done, addr_error
  );
endinterface

// File: rtl/gcn_row_bank.sv
// gcn_row_bank: row storage with element-serial writes and a registered full-row read
module gcn_row_bank #(
  parameter int NUM_ROWS = 3,
  parameter int ROW_LEN = 96,
  parameter int WIDTH = 5,
  localparam int RW = $clog2(NUM_ROWS),
  localparam int CW = $clog2(ROW_LEN)
) (
  input  logic clk,
  input  logic clr,
  input  logic we,
  input  logic [RW-1:0] wrow,
  input  logic [CW-1:0] wcol,
  input  logic [WIDTH-1:0] wdata,
  input  logic re,
  input  logic [RW-1:0] rrow,
  output logic [WIDTH-1:0] rdata [0:ROW_LEN-1]
);
  logic [WIDTH-1:0] mem [0:NUM_ROWS-1][0:ROW_LEN-1];
  // rdata samples mem before this edge's write, so a same-cycle read sees the old element
  always_ff @(posedge clk)
    if (clr) begin
      mem <= '{default: '0};
      rdata <= '{default: '0};
    end else begin
      if (we) mem[wrow][wcol] <= wdata;
      if (re) rdata <= mem[rrow];
    end
endmodule

// File: rtl/gcn_fm_wm_memory.sv
// gcn_fm_wm_memory: weight/feature row store with 1-cycle full-row reads and an element-serial load port.
// Define GCN_MEM_ADDR_CHECK_EN to flag out-of-range reads and load starts on the sticky addr_error.
module gcn_fm_wm_memory
  import gcn_mem_pkg::*;
(
  input logic clk,
  input logic reset,
  gcn_fm_wm_memory_if.slave bus
);
  localparam int WRW = $clog2(WEIGHT_COLS);
  localparam int FRW = $clog2(FEATURE_ROWS);
  load_state_t state;
  logic [COL_W-1:0] col;
  decode_t rd, ld, tgt;
  bank_sel_t rd_sel;
  logic wr;
  logic [WEIGHT_WIDTH-1:0] w_q [0:WEIGHT_ROWS-1];
  logic [FEATURE_WIDTH-1:0] f_q [0:FEATURE_COLS-1];
  assign rd = decode_addr(bus.read_address);
  assign ld = decode_addr(bus.load_address);
  assign wr = state == LOAD && bus.load_valid;
  assign bus.load_ready = state == LOAD;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      col <= '0;
      tgt <= '{bank: BANK_NONE, row: '0};
      rd_sel <= BANK_NONE;
      bus.data_valid <= 1'b0;
      bus.load_done <= 1'b0;
    end else begin
      bus.data_valid <= bus.enable_read;
      bus.load_done <= wr && col == LAST_COL;
      if (bus.enable_read) rd_sel <= rd.bank;
      if (state == IDLE && bus.load_start && ld.bank != BANK_NONE) begin
        state <= LOAD;
        col <= '0;
        tgt <= ld;
      end else if (wr) begin
        col <= col + 1'b1;
        if (col == LAST_COL) state <= IDLE;
      end
    end
  gcn_row_bank #(.NUM_ROWS(WEIGHT_COLS), .ROW_LEN(WEIGHT_ROWS), .WIDTH(WEIGHT_WIDTH)) u_weight (
    .clk(clk),
    .clr(reset),
    .we(wr && tgt.bank == BANK_WEIGHT),
    .wrow(tgt.row[WRW-1:0]),
    .wcol(col),
    .wdata(bus.load_data),
    .re(bus.enable_read && rd.bank == BANK_WEIGHT),
    .rrow(rd.row[WRW-1:0]),
    .rdata(w_q)
  );
  gcn_row_bank #(.NUM_ROWS(FEATURE_ROWS), .ROW_LEN(FEATURE_COLS), .WIDTH(FEATURE_WIDTH)) u_feature (
    .clk(clk),
    .clr(reset),
    .we(wr && tgt.bank == BANK_FEATURE),
    .wrow(tgt.row[FRW-1:0]),
    .wcol(col),
    .wdata(bus.load_data),
    .re(bus.enable_read && rd.bank == BANK_FEATURE),
    .rrow(rd.row[FRW-1:0]),
    .rdata(f_q)
  );
  // rd_sel follows the last read, so data_in holds (or stays zero) while reads pause
  always_comb
    for (int i = 0; i < ROW_LEN; i++)
      bus.data_in[i] = rd_sel == BANK_WEIGHT ? w_q[i] : rd_sel == BANK_FEATURE ? f_q[i] : '0;
`ifdef GCN_MEM_ADDR_CHECK_EN
  always_ff @(posedge clk)
    if (reset) bus.addr_error <= 1'b0;
    else if ((bus.enable_read && rd.bank == BANK_NONE) || (bus.load_start && ld.bank == BANK_NONE))
      bus.addr_error <= 1'b1;
`else
  assign bus.addr_error = 1'b0;
`endif
endmodule
